// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, GF(2^8) helpers, round-count function
// and the decrypt FSM state encoding.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_e;

  // Byte b of each table sits at bits [8*b +: 8], so entry 0 comes first.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for key-schedule step j (j >= 1): x^(j-1).
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = xtime(r);
    return r;
  endfunction

endpackage

// File: rtl/decrypt_iterative_if.sv
// Job/result handshake bundle for the iterative AES decryptor.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the job side and the result side.
interface decrypt_iterative_if #(parameter int Nk = 4);
  logic              in_valid;
  logic              in_ready;
  logic [0:127]      cipher_in;
  logic [0:Nk*32-1]  key;
  logic              out_valid;
  logic              out_ready;
  logic [0:127]      plain_out;

  modport master (output in_valid, cipher_in, key, out_ready,
                  input  in_ready, out_valid, plain_out);
  modport slave  (input  in_valid, cipher_in, key, out_ready,
                  output in_ready, out_valid, plain_out);
endinterface

// File: rtl/AddRoundKey.sv
// XOR of the 128-bit state with one round key.
// Latency: combinational.
// Backpressure: none.
module AddRoundKey
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] state_in,
  input  logic [0:BLOCK_W-1] round_key,
  output logic [0:BLOCK_W-1] state_out
);
  assign state_out = state_in ^ round_key;
endmodule

// File: rtl/KeyExpansion.sv
// Full AES key schedule: cipher key in, all Nr+1 round keys out (round r at [128*r +: 128]).
// Latency: combinational, single long path from key to the last round key.
// Backpressure: none.
module KeyExpansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_of(Nk)
) (
  input  logic [0:Nk*32-1]          key,
  output logic [0:(Nr+1)*BLOCK_W-1] w
);
  localparam int NW = 4 * (Nr + 1);

  // One generate block per schedule word so each word is its own net.
  for (genvar i = 0; i < NW; i++) begin : g_w
    logic [31:0] word;
    if (i < Nk) begin : g_key
      assign word = key[32*i +: 32];
    end else begin : g_exp
      logic [31:0] prev;
      logic [31:0] temp;
      assign prev = g_w[i-1].word;
      if (i % Nk == 0) begin : g_rot
        assign temp = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])}
                      ^ {rcon(i / Nk), 24'h000000};
      end else if (Nk > 6 && i % Nk == 4) begin : g_sub
        assign temp = {sbox(prev[31:24]), sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0])};
      end else begin : g_pass
        assign temp = prev;
      end
      assign word = g_w[i-Nk].word ^ temp;
    end
    assign w[32*i +: 32] = word;
  end
endmodule

// File: rtl/inv_cipher_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Latency: combinational.
// Backpressure: none.
// Ports: state_in/round_key 128-bit, last selects the final-round form, state_out 128-bit.
module inv_cipher_round
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] state_in,
  input  logic [0:BLOCK_W-1] round_key,
  input  logic               last,
  output logic [0:BLOCK_W-1] state_out
);
  logic [0:BLOCK_W-1] sub_s;
  logic [0:BLOCK_W-1] ark_s;
  logic [0:BLOCK_W-1] imc_s;

  function automatic logic [7:0] m9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Byte (row r, column c) lives at index r+4c; row r rotates right by r.
  always_comb begin
    sub_s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sub_s[8*(r+4*c) +: 8] = inv_sbox(state_in[8*(r+4*((c-r+4)%4)) +: 8]);
  end

  AddRoundKey u_ark (
    .state_in  (sub_s),
    .round_key (round_key),
    .state_out (ark_s)
  );

  always_comb begin
    imc_s = '0;
    for (int c = 0; c < 4; c++) begin
      imc_s[32*c +: 8]    = me(ark_s[32*c +: 8]) ^ mb(ark_s[32*c+8 +: 8])
                          ^ md(ark_s[32*c+16 +: 8]) ^ m9(ark_s[32*c+24 +: 8]);
      imc_s[32*c+8 +: 8]  = m9(ark_s[32*c +: 8]) ^ me(ark_s[32*c+8 +: 8])
                          ^ mb(ark_s[32*c+16 +: 8]) ^ md(ark_s[32*c+24 +: 8]);
      imc_s[32*c+16 +: 8] = md(ark_s[32*c +: 8]) ^ m9(ark_s[32*c+8 +: 8])
                          ^ me(ark_s[32*c+16 +: 8]) ^ mb(ark_s[32*c+24 +: 8]);
      imc_s[32*c+24 +: 8] = mb(ark_s[32*c +: 8]) ^ md(ark_s[32*c+8 +: 8])
                          ^ m9(ark_s[32*c+16 +: 8]) ^ me(ark_s[32*c+24 +: 8]);
    end
  end

  assign state_out = last ? ark_s : imc_s;
endmodule

// File: rtl/decrypt_iterative.sv
// Iterative AES inverse cipher, one round per clock; Nr = Nk+6 is derived internally.
// Latency: accept on edge E0 -> out_valid after edge E(Nr+1); job spacing Nr+3 cycles.
// Backpressure: in_ready low while busy (no queueing); result held in DONE until out_ready.
// Ports: clk, rst (sync, active-high), bus (slave: in_valid/in_ready/cipher_in/key,
//        out_valid/out_ready/plain_out; plain_out reads 0 whenever out_valid is 0).
module decrypt_iterative
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic               clk,
  input  logic               rst,
  decrypt_iterative_if.slave bus
);
  localparam int Nr = nr_of(Nk);

  fsm_e               fsm_q;
  logic [0:BLOCK_W-1] state_q;
  logic [0:Nk*32-1]   key_q;
  logic [3:0]         round_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [0:BLOCK_W-1] plain_q;

  logic [0:(Nr+1)*BLOCK_W-1] w_all;
  logic [0:BLOCK_W-1]        rk_arr [0:Nr];
  logic [0:BLOCK_W-1]        rk_sel;
  logic [0:BLOCK_W-1]        rnd_out;

  // Key schedule is recomputed from key_q every cycle rather than stored.
  KeyExpansion #(.Nk(Nk), .Nr(Nr)) u_kexp (
    .key (key_q),
    .w   (w_all)
  );

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk_arr[r] = w_all[r*BLOCK_W +: BLOCK_W];
  end

  // round_q has already reached 0 by FINAL, so it also selects w[0] there.
  assign rk_sel = (fsm_q == INIT) ? rk_arr[Nr] : rk_arr[round_q];

  inv_cipher_round u_round (
    .state_in  (state_q),
    .round_key (rk_sel),
    .last      (fsm_q == FINAL),
    .state_out (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      plain_q     <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q    <= bus.cipher_in;
            key_q      <= bus.key;
            in_ready_q <= 1'b0;
            fsm_q      <= INIT;
          end
        end
        INIT: begin
          state_q <= state_q ^ rk_sel;
          round_q <= 4'(Nr - 1);
          fsm_q   <= ROUND;
        end
        ROUND: begin
          state_q <= rnd_out;
          round_q <= round_q - 4'd1;
          if (round_q == 4'd1) fsm_q <= FINAL;
        end
        FINAL: begin
          state_q     <= rnd_out;
          plain_q     <= rnd_out;
          out_valid_q <= 1'b1;
          fsm_q       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            plain_q     <= '0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          plain_q     <= '0;
          in_ready_q  <= 1'b1;
          fsm_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.plain_out = plain_q;
endmodule

// File: tb/tb_decrypt_iterative.sv
module tb_decrypt_iterative;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid_v;
  logic         out_ready_v;
  logic [0:127] ct_v;
  logic [0:255] key_v;
  int           sel;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [0:127] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:255] APPB_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:127] C_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:255] C_KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C2_CT    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] C3_CT    = 128'h8ea2b7ca516745bfeafc49904b496089;

  decrypt_iterative_if #(.Nk(4)) if4 ();
  decrypt_iterative_if #(.Nk(6)) if6 ();
  decrypt_iterative_if #(.Nk(8)) if8 ();

  assign if4.in_valid  = in_valid_v && (sel == 4);
  assign if6.in_valid  = in_valid_v && (sel == 6);
  assign if8.in_valid  = in_valid_v && (sel == 8);
  assign if4.cipher_in = ct_v;
  assign if6.cipher_in = ct_v;
  assign if8.cipher_in = ct_v;
  assign if4.key       = key_v[0:127];
  assign if6.key       = key_v[0:191];
  assign if8.key       = key_v;
  assign if4.out_ready = out_ready_v;
  assign if6.out_ready = out_ready_v;
  assign if8.out_ready = out_ready_v;

  decrypt_iterative #(.Nk(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  decrypt_iterative #(.Nk(6)) u6 (.clk(clk), .rst(rst), .bus(if6.slave));
  decrypt_iterative #(.Nk(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

  logic         in_ready_m;
  logic         out_valid_m;
  logic [0:127] plain_m;

  always_comb begin
    case (sel)
      6: begin in_ready_m = if6.in_ready; out_valid_m = if6.out_valid; plain_m = if6.plain_out; end
      8: begin in_ready_m = if8.in_ready; out_valid_m = if8.out_valid; plain_m = if8.plain_out; end
      default: begin in_ready_m = if4.in_ready; out_valid_m = if4.out_valid; plain_m = if4.plain_out; end
    endcase
  end

  // Reference forward cipher used to build round-trip vectors.
  function automatic logic [0:127] aes_enc(input logic [0:127] pt, input logic [0:255] k, input int nk);
    logic [31:0]  w [0:59];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [0:15];
    logic [7:0]   u [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {aes_pkg::sbox(t[23:16]), aes_pkg::sbox(t[15:8]), aes_pkg::sbox(t[7:0]),
             aes_pkg::sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = aes_pkg::xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = {aes_pkg::sbox(t[31:24]), aes_pkg::sbox(t[23:16]), aes_pkg::sbox(t[15:8]),
             aes_pkg::sbox(t[7:0])};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) u[i] = aes_pkg::sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = u[rr+4*((c+rr)%4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = aes_pkg::xtime(a0) ^ aes_pkg::xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ aes_pkg::xtime(a1) ^ aes_pkg::xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ aes_pkg::xtime(a2) ^ aes_pkg::xtime(a3) ^ a3;
          s[4*c+3] = aes_pkg::xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_pkg::xtime(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready_m !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready timeout: in_ready=%b required 1", name, in_ready_m);
    end
  endtask

  task automatic run_job(input int nk, input logic [0:127] ct, input logic [0:255] k,
                         input logic [0:127] exp, input string name);
    int lat;
    sel = nk; ct_v = ct; key_v = k; out_ready_v = 1'b1;
    wait_ready(name);
    in_valid_v = 1'b1;
    @(negedge clk);
    in_valid_v = 1'b0;
    lat = 0;
    while (out_valid_m !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != nk + 7) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, nk + 7);
    end
    n_checks++;
    if (plain_m !== exp) begin
      n_fail++;
      $display("FAIL %s plaintext: got %h required %h", name, plain_m, exp);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || plain_m !== 128'h0) begin
      n_fail++;
      $display("FAIL %s after handshake: in_ready=%b out_valid=%b plain=%h required 1/0/0",
               name, in_ready_m, out_valid_m, plain_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid_v = 1'b0; out_ready_v = 1'b0; sel = 4; ct_v = '0; key_v = '0;
    repeat (2) @(negedge clk);
    for (int s = 4; s <= 8; s += 2) begin
      sel = s;
      #1;
      n_checks++;
      if (in_ready_m !== 1'b1) begin
        n_fail++; $display("FAIL reset in_ready Nk=%0d: got %b required 1", s, in_ready_m);
      end
      n_checks++;
      if (out_valid_m !== 1'b0) begin
        n_fail++; $display("FAIL reset out_valid Nk=%0d: got %b required 0", s, out_valid_m);
      end
      n_checks++;
      if (plain_m !== 128'h0) begin
        n_fail++; $display("FAIL reset plain_out Nk=%0d: got %h required 0", s, plain_m);
      end
    end
    sel = 4;
    rst = 1'b0;
  endtask

  task automatic test_kat_appb();
    run_job(4, APPB_CT, APPB_KEY, APPB_PT, "appB");
  endtask

  task automatic test_kat_c();
    run_job(4, C1_CT, C_KEY, C_PT, "C.1");
    run_job(6, C2_CT, C_KEY, C_PT, "C.2");
    run_job(8, C3_CT, C_KEY, C_PT, "C.3");
  endtask

  task automatic test_backpressure();
    int lat;
    sel = 4; ct_v = C1_CT; key_v = C_KEY; out_ready_v = 1'b0;
    wait_ready("bp");
    in_valid_v = 1'b1;
    @(negedge clk);
    in_valid_v = 1'b0;
    lat = 0;
    while (out_valid_m !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 11) begin
      n_fail++; $display("FAIL bp latency: got %0d required 11", lat);
    end
    n_checks++;
    if (plain_m !== C_PT) begin
      n_fail++; $display("FAIL bp plaintext: got %h required %h", plain_m, C_PT);
    end
    // A competing job with another key arrives while the result is held.
    in_valid_v = 1'b1; ct_v = APPB_CT; key_v = APPB_KEY;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || plain_m !== C_PT) begin
        n_fail++;
        $display("FAIL bp hold cycle %0d: out_valid=%b in_ready=%b plain=%h required 1/0/%h",
                 i, out_valid_m, in_ready_m, plain_m, C_PT);
      end
    end
    in_valid_v = 1'b0;
    out_ready_v = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL bp release: out_valid=%b in_ready=%b required 0/1", out_valid_m, in_ready_m);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid_m !== 1'b0) begin
        n_fail++; $display("FAIL bp ignored job produced output at cycle %0d: out_valid=%b required 0", i, out_valid_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 4; ct_v = APPB_CT; key_v = APPB_KEY; out_ready_v = 1'b1;
    wait_ready("rstmid");
    in_valid_v = 1'b1;
    @(negedge clk);
    in_valid_v = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || plain_m !== 128'h0) begin
      n_fail++;
      $display("FAIL rstmid state: in_ready=%b out_valid=%b plain=%h required 1/0/0",
               in_ready_m, out_valid_m, plain_m);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid_m !== 1'b0) begin
        n_fail++; $display("FAIL rstmid stray out_valid at cycle %0d: got %b required 0", i, out_valid_m);
      end
    end
    run_job(4, APPB_CT, APPB_KEY, APPB_PT, "rstmid_after");
  endtask

  task automatic test_back_to_back();
    int lat;
    sel = 4; ct_v = APPB_CT; key_v = APPB_KEY; out_ready_v = 1'b1;
    wait_ready("b2b");
    in_valid_v = 1'b1;
    @(negedge clk);
    ct_v = C1_CT; key_v = C_KEY;
    lat = 0;
    while (out_valid_m !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 11 || plain_m !== APPB_PT) begin
      n_fail++; $display("FAIL b2b first: lat=%0d plain=%h required 11/%h", lat, plain_m, APPB_PT);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
      n_fail++; $display("FAIL b2b idle gap: in_ready=%b out_valid=%b required 1/0", in_ready_m, out_valid_m);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready_m !== 1'b0) begin
      n_fail++; $display("FAIL b2b second accept: in_ready=%b required 0", in_ready_m);
    end
    in_valid_v = 1'b0;
    lat = 0;
    while (out_valid_m !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 11 || plain_m !== C_PT) begin
      n_fail++; $display("FAIL b2b second: lat=%0d plain=%h required 11/%h", lat, plain_m, C_PT);
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [0:127] pt;
    logic [0:255] k;
    int           nk;
    for (int i = 0; i < 200; i++) begin
      nk = (i % 3 == 0) ? 4 : ((i % 3 == 1) ? 6 : 8);
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(nk, aes_enc(pt, k, nk), k, pt, $sformatf("rt%0d_nk%0d", i, nk));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_kat_appb();
    test_kat_c();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decrypt_iterative.md
# decrypt_iterative

Iterative AES inverse cipher (FIPS-197 §5.3): accepts one 128-bit ciphertext block and a cipher key, runs one round per clock, and returns the plaintext block. It is the receive-side counterpart of the existing combinational encrypt path. It reuses the codebase's combinational `KeyExpansion` and `AddRoundKey` modules. It trades the encrypt path's fully unrolled datapath for a single round datapath, a round counter and a valid/ready handshake on both sides.

## Interface
- `Nk`, default 4: key length in 32-bit words; legal values are 4, 6, 8.
- `Nr`, default `Nk+6`: number of rounds. It is derived and must not be overridden.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `in_valid` input, 1 bit: ciphertext and key are valid.
- `in_ready` output, 1 bit: block can accept a new job.
- `cipher_in` input, [0:127]: ciphertext. Byte 0 is bits 0:7. State is column-major per FIPS-197.
- `key` input, [0:Nk*32-1]: cipher key, in the same byte order.
- `out_valid` output, 1 bit: plaintext is valid.
- `out_ready` input, 1 bit: downstream accepts the plaintext.
- `plain_out` output, [0:127]: plaintext.

## Operation
- FSM states:
  - **IDLE**: `in_ready`=1.
    - On `in_valid && in_ready`, latch `cipher_in` into `state_q` and `key` into `key_q`, then go to INIT.
  - **INIT**: `state_q <= state_q ^ w[Nr]`, where `w[r]` is round key r (128 bits) from `KeyExpansion(key_q)`.
    - Set `round_q <= Nr-1` and go to ROUND.
  - **ROUND**: `state_q <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_q)), w[round_q]))`.
    - Decrement `round_q`.
    - When `round_q`==1, go to FINAL after the update.
  - **FINAL**: `state_q <= AddRoundKey(InvSubBytes(InvShiftRows(state_q)), w[0])`, then go to DONE.
  - **DONE**: `out_valid`=1 and `plain_out`=`state_q`.
    - On `out_ready`, go to IDLE.
- `round_q` is 4 bits wide and counts down only. It never wraps, because INIT always loads a value of at least 9.
- `key_q` and `cipher_in` are sampled only on the input handshake. Changes on those inputs while the block is busy have no effect.
- `in_ready` is low in INIT, ROUND, FINAL and DONE. `in_valid` asserted during those states is ignored; there is no queueing.
- `plain_out` is 0 whenever `out_valid` is 0 (masked output).
- While in DONE, `plain_out` is stable until the output handshake completes.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `plain_out`=0. FSM=IDLE, `state_q`=0, `key_q`=0, `round_q`=0.
- `rst` asserted in any state (mid-round included) returns the block to IDLE on the next edge. The partial result is discarded and no `out_valid` pulse follows.
- Latency: input handshake on edge E0 makes `out_valid` high after edge E(Nr+1).
  - Nk=4: 11 cycles.
  - Nk=6: 13 cycles.
  - Nk=8: 15 cycles.
- If `out_ready` is high when DONE is entered, the output handshake completes in that first DONE cycle and `in_ready` is high the following cycle.
- Minimum job spacing is Nr+3 cycles.
- The `KeyExpansion` path is combinational from `key_q` and must settle within one cycle. It is the critical path and is not pipelined.

## Structure
- Shared package `aes_pkg`:
  - the inverse S-box table;
  - the function `nr_of(Nk)`;
  - the FSM state enum (IDLE, INIT, ROUND, FINAL, DONE);
  - the constant `BLOCK_W`=128.
- Sub-module `inv_cipher_round`: combinational, with ports `state_in`, `round_key`, `last`.
  - Performs InvShiftRows, then InvSubBytes, then AddRoundKey.
  - Applies InvMixColumns only when `last`=0.
  - Instantiates the existing `AddRoundKey`.
  - It is instantiated once; the FSM drives `last`=1 in FINAL.

## Test plan
- FIPS-197 App. B, Nk=4: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → `plain_out`=3243f6a8885a308d313198a2e0370734, `out_valid` exactly 11 cycles after accept.
- FIPS-197 C.1/C.2/C.3 (Nk=4/6/8), key 000102…(Nk*4 bytes) with ct 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 respectively → pt 00112233445566778899aabbccddeeff each; latency 11/13/15.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → `plain_out` stable and `in_ready`=0 throughout; a new `in_valid` with a different key is ignored and the result is unchanged.
- Reset mid-run: assert `rst` for 1 cycle 5 cycles after accept → next cycle `in_ready`=1, `out_valid`=0, `plain_out`=0. A following App. B job decrypts correctly.
- Back-to-back: two jobs (App. B, then C.1) with `out_ready`=1 and `in_valid` held high → both plaintexts correct, second accept exactly one cycle after the first output handshake.
- Round trip: 200 random key/pt pairs encrypted by the existing encrypt module, then fed to this block → plaintext recovered bit-exactly.
